key_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the lab up/down/load counter.
- Converts raw active-low DE10 KEY buttons and raw SW slide switches into clean synchronous signals:
  - debounced active-high key levels;
  - one-cycle press and release pulses;
  - 2-flop-synchronized switch values;
  - a programmable one-cycle count-enable tick.
- The counter stage consumes key_level/key_press for mode and load control, sw_sync for load data, and tick as its clock enable.

---
 rtl/key_conditioner.sv | 149 ++++++++++++++
 tb/tb_key_conditioner.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Input conditioning for the lab counter: synchronizes and debounces the
// active-low KEY buttons, synchronizes the SW switches, and generates a count-enable tick.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned SW_WIDTH        = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = 25000000
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [SW_WIDTH-1:0] sw_sync,
    output logic                tick
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        STABLE_UP,
        WAIT_DOWN,
        STABLE_DOWN,
        WAIT_UP
    } db_state_e;

    logic [NUM_KEYS-1:0] key_meta_q;
    logic [NUM_KEYS-1:0] key_sync_q;
    logic [SW_WIDTH-1:0] sw_meta_q;
    logic [SW_WIDTH-1:0] sw_sync_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    logic                tick_q;

    // Two-flop synchronizers; keys idle released (high) out of reset.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= key_n_raw;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        db_state_e        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             s;

        assign s = ~key_sync_q[i];

        // Per-key debounce: a level change is accepted only after the counter
        // reaches its terminal count with the sample held the whole time.
        always_ff @(posedge CLOCK_50 or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= STABLE_UP;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    STABLE_UP: begin
                        if (s) begin
                            state_q <= WAIT_DOWN;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    WAIT_DOWN: begin
                        if (!s) begin
                            state_q <= STABLE_UP;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= STABLE_DOWN;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                    STABLE_DOWN: begin
                        if (!s) begin
                            state_q <= WAIT_UP;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    WAIT_UP: begin
                        if (s) begin
                            state_q <= STABLE_DOWN;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q   <= STABLE_UP;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= STABLE_UP;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
    end

    // Free-running divider; tick is high the cycle after the terminal count.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            tick_q     <= 1'b0;
        end
    end

    assign sw_sync = sw_sync_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: instance a (debounce 4, tick 5) and
// instance b (debounce 1, tick 1). Inputs change and outputs are sampled on the falling edge.
module tb_key_conditioner;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_n_a, key_n_b;
    logic [9:0] sw_a, sw_b;
    logic [3:0] level_a, press_a, release_a;
    logic [3:0] level_b, press_b, release_b;
    logic [9:0] sw_sync_a, sw_sync_b;
    logic       tick_a, tick_b;

    int n_tests = 0;
    int n_fail  = 0;

    key_conditioner #(.NUM_KEYS(4), .SW_WIDTH(10), .DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut_a (
        .CLOCK_50(clk), .reset_n(reset_n), .key_n_raw(key_n_a), .sw_raw(sw_a),
        .key_level(level_a), .key_press(press_a), .key_release(release_a),
        .sw_sync(sw_sync_a), .tick(tick_a)
    );

    key_conditioner #(.NUM_KEYS(4), .SW_WIDTH(10), .DEBOUNCE_CYCLES(1), .TICK_DIV(1)) dut_b (
        .CLOCK_50(clk), .reset_n(reset_n), .key_n_raw(key_n_b), .sw_raw(sw_b),
        .key_level(level_b), .key_press(press_b), .key_release(release_b),
        .sw_sync(sw_sync_b), .tick(tick_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic exp_tick;
        n_tests++;
        if ({level_a, press_a, release_a, sw_sync_a, tick_a} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_a_outputs: got %h want 0", {level_a, press_a, release_a, sw_sync_a, tick_a});
        end
        n_tests++;
        if (tick_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b_tick: got %b want 0", tick_b);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            wait_n(1);
            exp_tick = (i % 5 == 0);
            n_tests++;
            if (tick_a !== exp_tick) begin
                n_fail++;
                $display("FAIL idle_tick_a edge %0d: got %b want %b", i, tick_a, exp_tick);
            end
            n_tests++;
            if (tick_b !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_tick_b edge %0d: got %b want 1", i, tick_b);
            end
        end
        n_tests++;
        if ({level_a, press_a, release_a} !== 12'd0) begin
            n_fail++;
            $display("FAIL idle_keys: got %h want 0", {level_a, press_a, release_a});
        end
    endtask

    task automatic test_clean_press();
        key_n_a[2] = 1'b0;
        wait_n(6);
        n_tests++;
        if (level_a !== 4'b0000 || press_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_early: level %b press %b want 0000 0000", level_a, press_a);
        end
        wait_n(1);
        n_tests++;
        if (level_a !== 4'b0100 || press_a !== 4'b0100 || release_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_edge6: level %b press %b rel %b want 0100 0100 0000", level_a, press_a, release_a);
        end
        wait_n(1);
        n_tests++;
        if (level_a !== 4'b0100 || press_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_one_cycle: level %b press %b want 0100 0000", level_a, press_a);
        end
        key_n_a[2] = 1'b1;
        wait_n(6);
        n_tests++;
        if (level_a !== 4'b0100 || release_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_early: level %b rel %b want 0100 0000", level_a, release_a);
        end
        wait_n(1);
        n_tests++;
        if (level_a !== 4'b0000 || release_a !== 4'b0100 || press_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_edge6: level %b rel %b press %b want 0000 0100 0000", level_a, release_a, press_a);
        end
        wait_n(1);
        n_tests++;
        if (release_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_one_cycle: got %b want 0000", release_a);
        end
    endtask

    task automatic test_glitch();
        int seen;
        int npress;
        seen = 0;
        key_n_a[1] = 1'b0;
        wait_n(3);
        key_n_a[1] = 1'b1;
        for (int j = 0; j < 12; j++) begin
            wait_n(1);
            if (level_a[1] || press_a[1] || release_a[1]) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL glitch_reject: activity cycles %0d want 0", seen);
        end
        npress = 0;
        key_n_a[1] = 1'b0;
        wait_n(1);
        key_n_a[1] = 1'b1;
        wait_n(1);
        key_n_a[1] = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            wait_n(1);
            if (press_a[1]) npress++;
            if (j == 6) begin
                n_tests++;
                if (press_a[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_early: got %b want 0", press_a[1]);
                end
            end
            if (j == 7) begin
                n_tests++;
                if (press_a !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL bounce_press: got %b want 0010", press_a);
                end
            end
        end
        n_tests++;
        if (npress !== 1 || level_a !== 4'b0010) begin
            n_fail++;
            $display("FAIL bounce_count: presses %0d level %b want 1 0010", npress, level_a);
        end
        key_n_a[1] = 1'b1;
        wait_n(10);
        n_tests++;
        if (level_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL bounce_release: level %b want 0000", level_a);
        end
    endtask

    task automatic test_sw_sync();
        sw_a = 10'd234;
        wait_n(1);
        n_tests++;
        if (sw_sync_a !== 10'd0) begin
            n_fail++;
            $display("FAIL sw_edge1: got %0d want 0", sw_sync_a);
        end
        wait_n(1);
        n_tests++;
        if (sw_sync_a !== 10'd234) begin
            n_fail++;
            $display("FAIL sw_edge2: got %0d want 234", sw_sync_a);
        end
    endtask

    task automatic test_simultaneous();
        key_n_a[1] = 1'b0;
        key_n_a[2] = 1'b0;
        wait_n(7);
        n_tests++;
        if (press_a !== 4'b0110 || level_a !== 4'b0110) begin
            n_fail++;
            $display("FAIL simul_press: press %b level %b want 0110 0110", press_a, level_a);
        end
        key_n_a[1] = 1'b1;
        key_n_a[2] = 1'b1;
        wait_n(7);
        n_tests++;
        if (release_a !== 4'b0110 || level_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL simul_release: rel %b level %b want 0110 0000", release_a, level_a);
        end
        wait_n(2);
    endtask

    task automatic test_reset_mid();
        key_n_a[3] = 1'b0;
        wait_n(8);
        n_tests++;
        if (level_a !== 4'b1000) begin
            n_fail++;
            $display("FAIL mid_pre_level: got %b want 1000", level_a);
        end
        key_n_a[0] = 1'b0;
        wait_n(3);
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({level_a, press_a, release_a, sw_sync_a, tick_a} !== 23'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %h want 0", {level_a, press_a, release_a, sw_sync_a, tick_a});
        end
        wait_n(1);
        reset_n = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            wait_n(1);
            if (j == 4 || j == 5) begin
                n_tests++;
                if (tick_a !== (j == 5)) begin
                    n_fail++;
                    $display("FAIL mid_tick edge %0d: got %b want %b", j, tick_a, (j == 5));
                end
            end
            if (j == 6 || j == 7) begin
                n_tests++;
                if (press_a !== ((j == 7) ? 4'b1001 : 4'b0000)) begin
                    n_fail++;
                    $display("FAIL mid_press edge %0d: got %b want %b", j, press_a, ((j == 7) ? 4'b1001 : 4'b0000));
                end
            end
        end
    endtask

    task automatic test_degenerate();
        int ticks;
        ticks = 0;
        for (int j = 0; j < 5; j++) begin
            wait_n(1);
            if (tick_b) ticks++;
        end
        n_tests++;
        if (ticks !== 5) begin
            n_fail++;
            $display("FAIL deg_tick: high cycles %0d want 5", ticks);
        end
        key_n_b[0] = 1'b0;
        wait_n(3);
        n_tests++;
        if (level_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL deg_press_early: got %b want 0000", level_b);
        end
        wait_n(1);
        n_tests++;
        if (level_b !== 4'b0001 || press_b !== 4'b0001) begin
            n_fail++;
            $display("FAIL deg_press: level %b press %b want 0001 0001", level_b, press_b);
        end
        wait_n(1);
        n_tests++;
        if (press_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL deg_press_one_cycle: got %b want 0000", press_b);
        end
        key_n_b[0] = 1'b1;
        wait_n(3);
        n_tests++;
        if (level_b !== 4'b0001) begin
            n_fail++;
            $display("FAIL deg_release_early: got %b want 0001", level_b);
        end
        wait_n(1);
        n_tests++;
        if (level_b !== 4'b0000 || release_b !== 4'b0001) begin
            n_fail++;
            $display("FAIL deg_release: level %b rel %b want 0000 0001", level_b, release_b);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_n_a = 4'b1111;
        key_n_b = 4'b1111;
        sw_a    = 10'd0;
        sw_b    = 10'd0;
        wait_n(3);
        test_reset();
        test_clean_press();
        test_glitch();
        test_sw_sync();
        test_simultaneous();
        test_reset_mid();
        test_degenerate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
